// File: rtl/battleship_pkg.sv
// Shared definitions for the battleship boards: board geometry, tile codes
// stored in the board RAM, game-control op codes, writer response codes and
// the writer FSM state type. The display block decodes the same tile codes.
package battleship_pkg;

    localparam logic [3:0] BOARD_DIM = 4'd10;
    localparam logic [2:0] MAX_LEN   = 3'd5;

    typedef enum logic [1:0] {
        TileEmpty = 2'd0,
        TileMiss  = 2'd1,
        TileHit   = 2'd2,
        TileShip  = 2'd3
    } tile_e;

    typedef enum logic [1:0] {
        OpNop   = 2'd0,
        OpClear = 2'd1,
        OpPlace = 2'd2,
        OpShot  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        RspOk     = 2'd0,
        RspReject = 2'd1,
        RspHit    = 2'd2,
        RspMiss   = 2'd3
    } rsp_e;

    typedef enum logic [3:0] {
        StIdle,
        StClr,
        StChk,
        StChkLast,
        StPlaceWr,
        StShotRd,
        StShotWait,
        StShotWr,
        StResp
    } wr_state_e;

    // Board RAM address: column in the upper nibble, row in the lower one.
    function automatic logic [9:0] cell_addr(input logic [3:0] x, input logic [3:0] y);
        return {2'b00, x, y};
    endfunction

endpackage

// File: rtl/board_cell_iter.sv
// Ship cell address generator.
// Ports:
//   x_i, y_i  start column / row of the ship
//   vert_i    0: step along x, 1: step along y
//   step_i    cell index along the ship (0 = start cell)
//   addr_o    packed board RAM address of that cell
module board_cell_iter
    import battleship_pkg::*;
(
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic       vert_i,
    input  logic [2:0] step_i,
    output logic [9:0] addr_o
);

    logic [3:0] step_ext;
    logic [3:0] cell_x;
    logic [3:0] cell_y;

    always_comb begin
        step_ext = {1'b0, step_i};
        cell_x   = x_i;
        cell_y   = y_i;
        if (vert_i) begin
            cell_y = y_i + step_ext;
        end else begin
            cell_x = x_i + step_ext;
        end
        addr_o = cell_addr(cell_x, cell_y);
    end

endmodule

// File: rtl/board_ram_writer.sv
// Write-side owner of one player board RAM. Executes CLEAR, PLACE and SHOT
// commands via the RAM's single read/write port with bounds and collision
// checks, reports a result code per command and tracks surviving ship cells.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only while idle)
//   cmd_op/x/y/len/vert      command fields, latched at accept
//   ram_addr/we/wdata/rdata  board RAM port (read data one cycle after address)
//   rsp_valid/rsp_code       completion pulse and held result code
//   cells_left, all_sunk     surviving ship cells and fleet-destroyed flag
module board_ram_writer
    import battleship_pkg::*;
#(
    parameter int unsigned RAM_RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_x,
    input  logic [3:0] cmd_y,
    input  logic [2:0] cmd_len,
    input  logic       cmd_vert,
    output logic [9:0] ram_addr,
    output logic       ram_we,
    output logic [1:0] ram_wdata,
    input  logic [1:0] ram_rdata,
    output logic       rsp_valid,
    output logic [1:0] rsp_code,
    output logic [4:0] cells_left,
    output logic       all_sunk
);

    // The check/shot sequencing assumes the read data returns one cycle after the address.
    if (RAM_RD_LAT != 1) begin : g_bad_rd_lat
        $error("board_ram_writer supports RAM_RD_LAT == 1 only");
    end

    wr_state_e  state_q, state_d;
    logic [3:0] x_q, x_d;
    logic [3:0] y_q, y_d;
    logic [2:0] len_q, len_d;
    logic       vert_q, vert_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] clr_cnt_q, clr_cnt_d;
    logic [9:0] ram_addr_q, ram_addr_d;
    logic       ram_we_q, ram_we_d;
    logic [1:0] ram_wdata_q, ram_wdata_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [1:0] rsp_code_q, rsp_code_d;
    logic [4:0] cells_left_q, cells_left_d;
    logic       all_sunk_q, all_sunk_d;
    logic       placed_q, placed_d;
    logic       cmd_ready_q, cmd_ready_d;

    logic [3:0] start_step;
    logic [4:0] end_step;
    logic       shot_legal;
    logic       place_legal;
    logic [5:0] place_sum;
    logic [2:0] iter_step;
    logic [9:0] iter_addr;

    // Address of the next ship cell; CHK_LAST rewinds to cell 0 for the write pass.
    assign iter_step = (state_q == StChkLast) ? 3'd0 : idx_q + 3'd1;

    board_cell_iter u_cell_iter (
        .x_i    (x_q),
        .y_i    (y_q),
        .vert_i (vert_q),
        .step_i (iter_step),
        .addr_o (iter_addr)
    );

    always_comb begin
        start_step  = cmd_vert ? cmd_y : cmd_x;
        end_step    = {1'b0, start_step} + {2'b00, cmd_len} - 5'd1;
        shot_legal  = (cmd_x < BOARD_DIM) && (cmd_y < BOARD_DIM);
        place_legal = shot_legal && (cmd_len != 3'd0) && (cmd_len <= MAX_LEN) &&
                      (end_step < {1'b0, BOARD_DIM});
        place_sum   = {1'b0, cells_left_q} + {3'b000, len_q};
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        len_d        = len_q;
        vert_d       = vert_q;
        idx_d        = idx_q;
        clr_cnt_d    = clr_cnt_q;
        ram_addr_d   = ram_addr_q;
        ram_we_d     = 1'b0;
        ram_wdata_d  = ram_wdata_q;
        rsp_valid_d  = 1'b0;
        rsp_code_d   = rsp_code_q;
        cells_left_d = cells_left_q;
        placed_d     = placed_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    x_d    = cmd_x;
                    y_d    = cmd_y;
                    len_d  = cmd_len;
                    vert_d = cmd_vert;
                    case (cmd_op)
                        OpClear: begin
                            state_d     = StClr;
                            clr_cnt_d   = 8'd0;
                            ram_addr_d  = 10'd0;
                            ram_we_d    = 1'b1;
                            ram_wdata_d = TileEmpty;
                        end
                        OpPlace: begin
                            if (place_legal) begin
                                state_d    = StChk;
                                idx_d      = 3'd0;
                                ram_addr_d = cell_addr(cmd_x, cmd_y);
                            end else begin
                                state_d     = StResp;
                                rsp_valid_d = 1'b1;
                                rsp_code_d  = RspReject;
                            end
                        end
                        OpShot: begin
                            if (shot_legal) begin
                                state_d    = StShotRd;
                                ram_addr_d = cell_addr(cmd_x, cmd_y);
                            end else begin
                                state_d     = StResp;
                                rsp_valid_d = 1'b1;
                                rsp_code_d  = RspReject;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            StClr: begin
                if (clr_cnt_q == 8'hFF) begin
                    state_d      = StResp;
                    rsp_valid_d  = 1'b1;
                    rsp_code_d   = RspOk;
                    cells_left_d = 5'd0;
                    placed_d     = 1'b0;
                end else begin
                    clr_cnt_d  = clr_cnt_q + 8'd1;
                    ram_addr_d = {2'b00, clr_cnt_q + 8'd1};
                    ram_we_d   = 1'b1;
                end
            end

            StChk: begin
                // rdata now belongs to the cell issued last cycle (none yet at idx 0).
                if ((idx_q != 3'd0) && (ram_rdata != TileEmpty)) begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_code_d  = RspReject;
                end else if (idx_q == len_q - 3'd1) begin
                    state_d = StChkLast;
                end else begin
                    idx_d      = idx_q + 3'd1;
                    ram_addr_d = iter_addr;
                end
            end

            StChkLast: begin
                if (ram_rdata != TileEmpty) begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_code_d  = RspReject;
                end else begin
                    state_d     = StPlaceWr;
                    idx_d       = 3'd0;
                    ram_addr_d  = iter_addr;
                    ram_we_d    = 1'b1;
                    ram_wdata_d = TileShip;
                end
            end

            StPlaceWr: begin
                if (idx_q == len_q - 3'd1) begin
                    state_d      = StResp;
                    rsp_valid_d  = 1'b1;
                    rsp_code_d   = RspOk;
                    cells_left_d = place_sum[5] ? 5'd31 : place_sum[4:0];
                    placed_d     = 1'b1;
                end else begin
                    idx_d      = idx_q + 3'd1;
                    ram_addr_d = iter_addr;
                    ram_we_d   = 1'b1;
                end
            end

            StShotRd: begin
                state_d = StShotWait;
            end

            StShotWait: begin
                if (ram_rdata == TileShip) begin
                    state_d     = StShotWr;
                    ram_we_d    = 1'b1;
                    ram_wdata_d = TileHit;
                end else if (ram_rdata == TileEmpty) begin
                    state_d     = StShotWr;
                    ram_we_d    = 1'b1;
                    ram_wdata_d = TileMiss;
                end else begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_code_d  = RspReject;
                end
            end

            StShotWr: begin
                state_d     = StResp;
                rsp_valid_d = 1'b1;
                if (ram_wdata_q == TileHit) begin
                    rsp_code_d = RspHit;
                    if (cells_left_q != 5'd0) begin
                        cells_left_d = cells_left_q - 5'd1;
                    end
                end else begin
                    rsp_code_d = RspMiss;
                end
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        all_sunk_d  = (cells_left_d == 5'd0) && placed_d;
        cmd_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            x_q          <= 4'd0;
            y_q          <= 4'd0;
            len_q        <= 3'd0;
            vert_q       <= 1'b0;
            idx_q        <= 3'd0;
            clr_cnt_q    <= 8'd0;
            ram_addr_q   <= 10'd0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= 2'd0;
            rsp_valid_q  <= 1'b0;
            rsp_code_q   <= 2'd0;
            cells_left_q <= 5'd0;
            all_sunk_q   <= 1'b0;
            placed_q     <= 1'b0;
            cmd_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            len_q        <= len_d;
            vert_q       <= vert_d;
            idx_q        <= idx_d;
            clr_cnt_q    <= clr_cnt_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_code_q   <= rsp_code_d;
            cells_left_q <= cells_left_d;
            all_sunk_q   <= all_sunk_d;
            placed_q     <= placed_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_code   = rsp_code_q;
    assign cells_left = cells_left_q;
    assign all_sunk   = all_sunk_q;

endmodule

// File: tb/tb_board_ram_writer.sv
// Scoreboard bench for board_ram_writer: directed commands push expected RAM
// writes and responses (with their cycle) into queues; a monitor process pops
// and compares whenever the DUT strobes ram_we or rsp_valid.
module tb_board_ram_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [3:0] cmd_x = 4'd0;
    logic [3:0] cmd_y = 4'd0;
    logic [2:0] cmd_len = 3'd0;
    logic       cmd_vert = 1'b0;
    logic [9:0] ram_addr;
    logic       ram_we;
    logic [1:0] ram_wdata;
    logic [1:0] ram_rdata;
    logic       rsp_valid;
    logic [1:0] rsp_code;
    logic [4:0] cells_left;
    logic       all_sunk;

    // Bench-side board RAM with a backdoor write port for preloading cells.
    logic [1:0] mem [256];
    logic       bd_we = 1'b0;
    logic [7:0] bd_addr = 8'd0;
    logic [1:0] bd_data = 2'd0;

    typedef struct {
        int         cyc;
        logic [9:0] addr;
        logic [1:0] data;
    } wr_t;

    typedef struct {
        string      name;
        int         cyc;
        logic [1:0] code;
        logic [4:0] cl;
        logic       sunk;
    } rsp_t;

    wr_t  wq[$];
    rsp_t rq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    board_ram_writer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_len    (cmd_len),
        .cmd_vert   (cmd_vert),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_code   (rsp_code),
        .cells_left (cells_left),
        .all_sunk   (all_sunk)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (ram_we) begin
            mem[ram_addr[7:0]] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr[7:0]];
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: every cycle, compare DUT strobes against the scoreboard.
    initial begin
        wr_t  w;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (ram_we === 1'b1) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write cyc=%0d got addr=%h data=%0d, required none",
                             cyc, ram_addr, ram_wdata);
                end else begin
                    w = wq.pop_front();
                    if (w.cyc != cyc || ram_addr !== w.addr || ram_wdata !== w.data) begin
                        errors++;
                        $display("FAIL ram_write got cyc=%0d addr=%h data=%0d, required cyc=%0d addr=%h data=%0d",
                                 cyc, ram_addr, ram_wdata, w.cyc, w.addr, w.data);
                    end
                end
            end
            if (rsp_valid === 1'b1) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp cyc=%0d got code=%0d, required none",
                             cyc, rsp_code);
                end else begin
                    r = rq.pop_front();
                    if (r.cyc != cyc || rsp_code !== r.code || cells_left !== r.cl ||
                        all_sunk !== r.sunk) begin
                        errors++;
                        $display("FAIL rsp_%s got cyc=%0d code=%0d cells_left=%0d all_sunk=%0d, required cyc=%0d code=%0d cells_left=%0d all_sunk=%0d",
                                 r.name, cyc, rsp_code, cells_left, all_sunk,
                                 r.cyc, r.code, r.cl, r.sunk);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_wr(input int c, input logic [9:0] a, input logic [1:0] d);
        wr_t w;
        w.cyc  = c;
        w.addr = a;
        w.data = d;
        wq.push_back(w);
    endtask

    task automatic push_rsp(input string name, input int c, input logic [1:0] code,
                            input logic [4:0] cl, input logic sunk);
        rsp_t r;
        r.name = name;
        r.cyc  = c;
        r.code = code;
        r.cl   = cl;
        r.sunk = sunk;
        rq.push_back(r);
    endtask

    task automatic poke(input logic [7:0] a, input logic [1:0] d);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Present a command at a negedge; t is the accept cycle T.
    task automatic drive(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y,
                         input logic [2:0] len, input logic vert, output int t);
        @(negedge clk);
        chk("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = x;
        cmd_y     = y;
        cmd_len   = len;
        cmd_vert  = vert;
        t         = cyc;
    endtask

    // Drop the command (scrambling the fields) and wait for the scoreboard to drain.
    task automatic complete(input string name, input int budget);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_x     = 4'($urandom);
        cmd_y     = 4'($urandom);
        cmd_len   = 3'($urandom);
        cmd_vert  = 1'($urandom);
        for (int i = 0; i < budget && (wq.size() != 0 || rq.size() != 0); i++) begin
            @(negedge clk);
        end
        if (wq.size() != 0 || rq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got pending writes=%0d rsps=%0d, required 0 and 0",
                     name, wq.size(), rq.size());
            wq.delete();
            rq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int t;

        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_ram_we", 32'(ram_we), 32'd0);
        chk("reset_ram_addr", 32'(ram_addr), 32'd0);
        chk("reset_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_code", 32'(rsp_code), 32'd0);
        chk("reset_cells_left", 32'(cells_left), 32'd0);
        chk("reset_all_sunk", 32'(all_sunk), 32'd0);
        rst = 1'b0;

        // CLEAR: 256 writes of EMPTY, ascending, then OK.
        drive(2'd1, 4'd0, 4'd0, 3'd0, 1'b0, t);
        for (int k = 0; k < 256; k++) push_wr(t + 1 + k, 10'(k), 2'd0);
        push_rsp("clear", t + 257, 2'd0, 5'd0, 1'b0);
        complete("clear", 300);

        // Horizontal ship at (2,3) len 4.
        drive(2'd2, 4'd2, 4'd3, 3'd4, 1'b0, t);
        push_wr(t + 6, 10'h023, 2'd3);
        push_wr(t + 7, 10'h033, 2'd3);
        push_wr(t + 8, 10'h043, 2'd3);
        push_wr(t + 9, 10'h053, 2'd3);
        push_rsp("place_h4", t + 10, 2'd0, 5'd4, 1'b0);
        complete("place_h4", 30);

        // Bounds rejects: end column 10, len 0, len 6.
        drive(2'd2, 4'd7, 4'd0, 3'd4, 1'b0, t);
        push_rsp("place_oob", t + 1, 2'd1, 5'd4, 1'b0);
        complete("place_oob", 10);
        drive(2'd2, 4'd0, 4'd0, 3'd0, 1'b0, t);
        push_rsp("place_len0", t + 1, 2'd1, 5'd4, 1'b0);
        complete("place_len0", 10);
        drive(2'd2, 4'd0, 4'd0, 3'd6, 1'b0, t);
        push_rsp("place_len6", t + 1, 2'd1, 5'd4, 1'b0);
        complete("place_len6", 10);

        // Vertical ship over a preloaded SHIP at 0x51: collision on cell 1.
        poke(8'h51, 2'd3);
        drive(2'd2, 4'd5, 4'd0, 3'd3, 1'b1, t);
        push_rsp("place_collide", t + 4, 2'd1, 5'd4, 1'b0);
        complete("place_collide", 20);

        // Shots.
        drive(2'd3, 4'd4, 4'd3, 3'd0, 1'b0, t);
        push_wr(t + 3, 10'h043, 2'd2);
        push_rsp("shot_hit", t + 4, 2'd2, 5'd3, 1'b0);
        complete("shot_hit", 10);
        drive(2'd3, 4'd4, 4'd3, 3'd0, 1'b0, t);
        push_rsp("shot_repeat", t + 3, 2'd1, 5'd3, 1'b0);
        complete("shot_repeat", 10);
        drive(2'd3, 4'd0, 4'd0, 3'd0, 1'b0, t);
        push_wr(t + 3, 10'h000, 2'd1);
        push_rsp("shot_miss", t + 4, 2'd3, 5'd3, 1'b0);
        complete("shot_miss", 10);
        drive(2'd3, 4'd10, 4'd0, 3'd0, 1'b0, t);
        push_rsp("shot_oob_x", t + 1, 2'd1, 5'd3, 1'b0);
        complete("shot_oob_x", 10);
        drive(2'd3, 4'd0, 4'd15, 3'd0, 1'b0, t);
        push_rsp("shot_oob_y", t + 1, 2'd1, 5'd3, 1'b0);
        complete("shot_oob_y", 10);

        // NOP: no response, no writes.
        drive(2'd0, 4'd3, 4'd3, 3'd2, 1'b0, t);
        complete("nop", 10);
        chk("nop_cells_left", 32'(cells_left), 32'd3);

        // Sink the rest of the ship.
        drive(2'd3, 4'd2, 4'd3, 3'd0, 1'b0, t);
        push_wr(t + 3, 10'h023, 2'd2);
        push_rsp("sink_1", t + 4, 2'd2, 5'd2, 1'b0);
        complete("sink_1", 10);
        drive(2'd3, 4'd3, 4'd3, 3'd0, 1'b0, t);
        push_wr(t + 3, 10'h033, 2'd2);
        push_rsp("sink_2", t + 4, 2'd2, 5'd1, 1'b0);
        complete("sink_2", 10);
        drive(2'd3, 4'd5, 4'd3, 3'd0, 1'b0, t);
        push_wr(t + 3, 10'h053, 2'd2);
        push_rsp("sink_last", t + 4, 2'd2, 5'd0, 1'b1);
        complete("sink_last", 10);
        chk("all_sunk_held", 32'(all_sunk), 32'd1);

        // Longest legal ship, vertical, ending on the last row.
        drive(2'd2, 4'd9, 4'd5, 3'd5, 1'b1, t);
        for (int k = 0; k < 5; k++) push_wr(t + 7 + k, 10'h095 + 10'(k), 2'd3);
        push_rsp("place_v5", t + 12, 2'd0, 5'd5, 1'b0);
        complete("place_v5", 30);
        drive(2'd2, 4'd9, 4'd6, 3'd5, 1'b1, t);
        push_rsp("place_v5_oob", t + 1, 2'd1, 5'd5, 1'b0);
        complete("place_v5_oob", 10);

        // Single-cell ship in the corner.
        drive(2'd2, 4'd0, 4'd9, 3'd1, 1'b0, t);
        push_wr(t + 3, 10'h009, 2'd3);
        push_rsp("place_len1", t + 4, 2'd0, 5'd6, 1'b0);
        complete("place_len1", 10);

        // Reset in the middle of CLEAR after addresses 0x00..0x10 are written.
        poke(8'h10, 2'd1);
        poke(8'h11, 2'd1);
        drive(2'd1, 4'd0, 4'd0, 3'd0, 1'b0, t);
        for (int k = 0; k < 17; k++) push_wr(t + 1 + k, 10'(k), 2'd0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        while (cyc < t + 17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ram_we", 32'(ram_we), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_cells_left", 32'(cells_left), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_pending_writes", 32'(wq.size()), 32'd0);
        chk("midrst_mem_00", 32'(mem[8'h00]), 32'd0);
        chk("midrst_mem_10", 32'(mem[8'h10]), 32'd0);
        chk("midrst_mem_11", 32'(mem[8'h11]), 32'd1);
        chk("midrst_mem_23", 32'(mem[8'h23]), 32'd2);
        chk("midrst_mem_95", 32'(mem[8'h95]), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
